stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Run/pause/lap/clear controller for a 4-digit BCD elapsed-count chain, each digit wrapping 9 to 0.
- A prescaler generates the count tick from the system clock.
- Sequences the chain from single-cycle command pulses and drives a 16-bit display value, live or lap-frozen.
- Sits between the debounced button/pulse logic and the 7-segment display driver.

Parameters:
- PRESCALE, 16'd50000: clock cycles per count increment; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  single-cycle pulse: begin or resume counting.
- stop  input  1  single-cycle pulse: pause counting.
- lap  input  1  single-cycle pulse: freeze or release the display (split).
- clear  input  1  single-cycle pulse: return to idle with count zeroed.
- display  output  16  four BCD digits, [15:12] most significant; live count or lap value.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP.
- overflow  output  1  sticky; set when the count wraps 9999 to 0000.
- tick  output  1  one-cycle pulse on each edge where the count increments.

Behaviour:
- Reset (rst low at a clk edge): state IDLE; count, lap_reg, prescaler cleared; all outputs 0. Reset mid-count discards everything.
- States: IDLE, RUN, PAUSE, LAP. Command priority when pulses coincide: clear > stop > start > lap. Only the highest-priority command valid in the current state acts; the rest are ignored that cycle.
- clear, from any state: to IDLE; count, lap_reg, prescaler, overflow all cleared.
- start:
  - IDLE to RUN with prescaler 0.
  - PAUSE to RUN with prescaler value preserved.
  - Ignored in RUN and LAP.
- stop: RUN or LAP to PAUSE; display returns to live count. Ignored in IDLE and PAUSE.
- lap:
  - In RUN: lap_reg <= current count (pre-increment value if a tick occurs the same edge); to LAP.
  - In LAP: to RUN (display live again).
  - Ignored in IDLE and PAUSE.
- Prescaler advances only while the state is RUN or LAP and no state-changing command is accepted that edge.
- At prescaler == PRESCALE-1:
  - prescaler <= 0; count increments; tick = 1 for that cycle.
  - tick is registered, asserted in the cycle after the edge where the count changes.
- PRESCALE = 1: increments every cycle while counting.
- An accepted stop on a terminal-prescaler edge suppresses the increment; the prescaler holds at PRESCALE-1, so the first edge after resuming increments.
- Count arithmetic: BCD ripple.
  - Digit 0 increments.
  - Each digit at 9 wraps to 0 and carries to the next digit.
  - 9999 wraps to 0000 and sets overflow. overflow stays set until clear or reset; counting continues.
- display = lap_reg in LAP, else the live count. running and lap_active decode directly from the registered state, with no extra latency.
- Latency: start accepted at edge N gives running = 1 after edge N. The first increment lands at edge N + PRESCALE.

Test Plan:
- PRESCALE=4: reset, pulse start at edge 0 -> running=1 after edge 0; display 0001 after edge 4, 0002 after edge 8; tick high one cycle each.
- PRESCALE=1: preload to 9998 by counting, two more ticks -> display 9999 then 0000, overflow=1; later clear -> display 0000, overflow=0, state IDLE.
- PRESCALE=4: count to 0012, pulse lap -> display frozen at 0012 while the live count advances to 0015; pulse lap again -> display shows 0015 live, lap_active=0.
- PRESCALE=4: stop on the same edge as the prescaler terminal -> no increment, running=0; start 3 cycles later -> increment on the very next edge.
- Simultaneous clear+start+lap in RUN -> IDLE, display 0000; simultaneous stop+start in RUN -> PAUSE; start in RUN alone -> no change.
- Hold rst low for one edge mid-count at display 0347 in LAP -> all outputs 0, IDLE; with rst high and no commands, display stays 0000.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl_if
// Command/status bundle between the button pulse logic (master) and the
// stopwatch controller (slave).
//   start, stop, lap, clear : single-cycle command pulses, master -> slave
//   display                 : four BCD digits, [15:12] most significant
//   running, lap_active     : state decode (RUN or LAP / LAP only)
//   overflow                : sticky 9999 -> 0000 wrap flag
//   tick                    : one-cycle pulse after each count increment
// ----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  logic        start;
  logic        stop;
  logic        lap;
  logic        clear;
  logic [15:0] display;
  logic        running;
  logic        lap_active;
  logic        overflow;
  logic        tick;

  modport master (
    output start, stop, lap, clear,
    input  display, running, lap_active, overflow, tick
  );

  modport slave (
    input  start, stop, lap, clear,
    output display, running, lap_active, overflow, tick
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl
// Run/pause/lap/clear controller for a 4-digit BCD elapsed-count chain.
// A prescaler divides clk by PRESCALE to produce the count increment.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   sw   : stopwatch_ctrl_if.slave (commands in, display/status out)
// All outputs are registered; they are loaded from the next-state values so
// they appear with no extra latency relative to the state register.
// ----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter logic [15:0] PRESCALE = 16'd50000
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam logic [15:0] PRE_LAST = PRESCALE - 16'd1;

  state_t      state_r, state_nxt_s;
  logic [15:0] count_r, count_nxt_s;
  logic [15:0] lap_r, lap_nxt_s;
  logic [15:0] pre_r, pre_nxt_s;
  logic        ovf_r, ovf_nxt_s;
  logic        tick_r;
  logic [15:0] disp_r;
  logic        run_r;
  logic        lapa_r;
  logic        acc_s;      // a state-changing command is taken this edge
  logic        clr_s;      // clear taken this edge
  logic        inc_s;      // count increments this edge
  logic [16:0] inc_val_s;  // {wrap carry, incremented BCD count}

  // BCD ripple increment; bit 16 is the carry out of the top digit.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return {c, r};
  endfunction

  // Next-state, command arbitration, prescaler and count update.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    lap_nxt_s   = lap_r;
    pre_nxt_s   = pre_r;
    ovf_nxt_s   = ovf_r;
    acc_s       = 1'b0;
    clr_s       = 1'b0;
    inc_s       = 1'b0;
    inc_val_s   = bcd_inc(count_r);

    // Priority clear > stop > start > lap; only commands legal in the
    // current state are considered, so e.g. start+lap in RUN acts as lap.
    case (state_r)
      IDLE: begin
        if (sw.clear) begin
          acc_s = 1'b1;
          clr_s = 1'b1;
        end else if (sw.start) begin
          acc_s       = 1'b1;
          state_nxt_s = RUN;
          pre_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PAUSE: begin
        if (sw.clear) begin
          acc_s = 1'b1;
          clr_s = 1'b1;
        end else if (sw.start) begin
          // Prescaler is kept so a stop on the terminal edge resumes promptly.
          acc_s       = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = PAUSE;
        end
      end
      RUN: begin
        if (sw.clear) begin
          acc_s = 1'b1;
          clr_s = 1'b1;
        end else if (sw.stop) begin
          acc_s       = 1'b1;
          state_nxt_s = PAUSE;
        end else if (sw.lap) begin
          acc_s       = 1'b1;
          state_nxt_s = LAP;
          lap_nxt_s   = count_r;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LAP: begin
        if (sw.clear) begin
          acc_s = 1'b1;
          clr_s = 1'b1;
        end else if (sw.stop) begin
          acc_s       = 1'b1;
          state_nxt_s = PAUSE;
        end else if (sw.lap) begin
          acc_s       = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = LAP;
        end
      end
      default: begin
        acc_s = 1'b1;
        clr_s = 1'b1;
      end
    endcase

    // The prescaler only moves on edges where no command is taken.
    if (!acc_s && ((state_r == RUN) || (state_r == LAP))) begin
      if (pre_r == PRE_LAST) begin
        pre_nxt_s   = 16'd0;
        inc_s       = 1'b1;
        count_nxt_s = inc_val_s[15:0];
        if (inc_val_s[16]) begin
          ovf_nxt_s = 1'b1;
        end else begin
          ovf_nxt_s = ovf_r;
        end
      end else begin
        pre_nxt_s = pre_r + 16'd1;
      end
    end else begin
      inc_s = 1'b0;
    end

    if (clr_s) begin
      state_nxt_s = IDLE;
      count_nxt_s = 16'd0;
      lap_nxt_s   = 16'd0;
      pre_nxt_s   = 16'd0;
      ovf_nxt_s   = 1'b0;
    end else begin
      ovf_nxt_s = ovf_nxt_s;
    end
  end

  // State, datapath and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      count_r <= 16'd0;
      lap_r   <= 16'd0;
      pre_r   <= 16'd0;
      ovf_r   <= 1'b0;
      tick_r  <= 1'b0;
      disp_r  <= 16'd0;
      run_r   <= 1'b0;
      lapa_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      lap_r   <= lap_nxt_s;
      pre_r   <= pre_nxt_s;
      ovf_r   <= ovf_nxt_s;
      tick_r  <= inc_s;
      disp_r  <= (state_nxt_s == LAP) ? lap_nxt_s : count_nxt_s;
      run_r   <= (state_nxt_s == RUN) || (state_nxt_s == LAP);
      lapa_r  <= (state_nxt_s == LAP);
    end
  end

  assign sw.display    = disp_r;
  assign sw.running    = run_r;
  assign sw.lap_active = lapa_r;
  assign sw.overflow   = ovf_r;
  assign sw.tick       = tick_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Two controllers: dut_a with PRESCALE=4, dut_b with PRESCALE=1. The stimulus
// thread issues commands and pushes hand-computed expected outputs, stamped
// with the cycle they apply to, into a scoreboard queue. A separate monitor
// pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    int          cyc;
    bit          sel;    // 0: dut_a, 1: dut_b
    logic [15:0] disp;
    logic        run;
    logic        lapa;
    logic        ovf;
    logic        tck;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  stopwatch_ctrl_if sw_a ();
  stopwatch_ctrl_if sw_b ();

  stopwatch_ctrl #(.PRESCALE(16'd4)) dut_a (.clk(clk), .rst(rst_a), .sw(sw_a));
  stopwatch_ctrl #(.PRESCALE(16'd1)) dut_b (.clk(clk), .rst(rst_b), .sw(sw_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t        e;
      logic [15:0] ad;
      logic        ar, al, ao, at;
      e = exp_q.pop_front();
      if (e.sel) begin
        ad = sw_b.display; ar = sw_b.running; al = sw_b.lap_active;
        ao = sw_b.overflow; at = sw_b.tick;
      end else begin
        ad = sw_a.display; ar = sw_a.running; al = sw_a.lap_active;
        ao = sw_a.overflow; at = sw_a.tick;
      end
      checks++;
      if ({ad, ar, al, ao, at} !== {e.disp, e.run, e.lapa, e.ovf, e.tck}) begin
        errors++;
        $display("FAIL %s: got disp=%h run=%b lap=%b ovf=%b tick=%b, want disp=%h run=%b lap=%b ovf=%b tick=%b",
                 e.name, ad, ar, al, ao, at, e.disp, e.run, e.lapa, e.ovf, e.tck);
      end
    end
  end

  task automatic expect_out(input bit sel, input logic [15:0] d, input logic r,
                            input logic la, input logic o, input logic t,
                            input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.disp = d; e.run = r; e.lapa = la;
    e.ovf = o; e.tck = t; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle command pulse accepted on the next rising edge.
  task automatic cmd(input bit sel, input logic s, input logic p,
                     input logic l, input logic c);
    if (sel) begin
      sw_b.start = s; sw_b.stop = p; sw_b.lap = l; sw_b.clear = c;
    end else begin
      sw_a.start = s; sw_a.stop = p; sw_a.lap = l; sw_a.clear = c;
    end
    step(1);
    sw_a.start = 1'b0; sw_a.stop = 1'b0; sw_a.lap = 1'b0; sw_a.clear = 1'b0;
    sw_b.start = 1'b0; sw_b.stop = 1'b0; sw_b.lap = 1'b0; sw_b.clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    sw_a.start = 1'b0; sw_a.stop = 1'b0; sw_a.lap = 1'b0; sw_a.clear = 1'b0;
    sw_b.start = 1'b0; sw_b.stop = 1'b0; sw_b.lap = 1'b0; sw_b.clear = 1'b0;
    step(2);
    expect_out(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "reset_a");
    expect_out(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "reset_b");
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(1);
    expect_out(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "idle_a");

    // ---- PRESCALE=4: first increments at start+4, start+8 ----
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, "start_running");
    for (int k = 1; k <= 8; k++) begin
      step(1);
      expect_out(1'b0, 16'(k / 4), 1'b1, 1'b0, 1'b0, (k % 4) == 0, "count_p4");
    end
    step(40);
    expect_out(1'b0, 16'h0012, 1'b1, 1'b0, 1'b0, 1'b1, "reach_0012");

    // ---- lap freeze / release ----
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out(1'b0, 16'h0012, 1'b1, 1'b1, 1'b0, 1'b0, "lap_freeze");
    step(12);  // live count reaches 0015 on this edge
    expect_out(1'b0, 16'h0012, 1'b1, 1'b1, 1'b0, 1'b1, "lap_frozen_live_ticks");
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out(1'b0, 16'h0015, 1'b1, 1'b0, 1'b0, 1'b0, "lap_release");

    // ---- stop on the terminal prescaler edge ----
    step(3);
    expect_out(1'b0, 16'h0015, 1'b1, 1'b0, 1'b0, 1'b0, "pre_terminal");
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out(1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 1'b0, "stop_on_terminal");
    step(3);
    expect_out(1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 1'b0, "paused_hold");
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(1'b0, 16'h0015, 1'b1, 1'b0, 1'b0, 1'b0, "resume");
    step(1);
    expect_out(1'b0, 16'h0016, 1'b1, 1'b0, 1'b0, 1'b1, "resume_inc_next_edge");

    // ---- priority ----
    cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out(1'b0, 16'h0016, 1'b0, 1'b0, 1'b0, 1'b0, "stop_beats_start");
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(1'b0, 16'h0016, 1'b1, 1'b0, 1'b0, 1'b0, "restart");
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(1'b0, 16'h0016, 1'b1, 1'b0, 1'b0, 1'b0, "start_in_run_ignored");
    step(2);
    expect_out(1'b0, 16'h0016, 1'b1, 1'b0, 1'b0, 1'b0, "pre_kept_1");
    step(1);
    expect_out(1'b0, 16'h0017, 1'b1, 1'b0, 1'b0, 1'b1, "pre_kept_inc");
    cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out(1'b0, 16'h0017, 1'b1, 1'b1, 1'b0, 1'b0, "start_lap_in_run_is_lap");
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out(1'b0, 16'h0017, 1'b1, 1'b0, 1'b0, 1'b0, "back_to_run");
    cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_out(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "clear_beats_all");
    step(2);
    expect_out(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "idle_after_clear");

    // ---- PRESCALE=1: wrap and overflow ----
    cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, "b_start");
    step(9998);
    expect_out(1'b1, 16'h9998, 1'b1, 1'b0, 1'b0, 1'b1, "b_9998");
    step(1);
    expect_out(1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1, "b_9999");
    step(1);
    expect_out(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, "b_wrap_overflow");
    step(1);
    expect_out(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1, "b_overflow_sticky");
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "b_clear");

    // ---- reset mid-count while in LAP at 0347 ----
    cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(347);
    expect_out(1'b1, 16'h0347, 1'b1, 1'b0, 1'b0, 1'b1, "b_0347");
    cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out(1'b1, 16'h0347, 1'b1, 1'b1, 1'b0, 1'b0, "b_lap_0347");
    step(2);
    expect_out(1'b1, 16'h0347, 1'b1, 1'b1, 1'b0, 1'b1, "b_lap_hold");
    rst_b = 1'b0;
    step(1);
    expect_out(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "b_reset_mid");
    rst_b = 1'b1;
    step(3);
    expect_out(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "b_idle_after_reset");

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
      step(1);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
